// File: rtl/regarb_pkg.sv
// regarb_pkg: shared types and helpers for the GPU register-file port arbiter.
//   arb_state_e  : issue-slot FSM states (IDLE / ISSUE / HOLD)
//   clog2_min1() : index/address width helper that never returns 0
package regarb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2
  } arb_state_e;

  // Width of an index into n items; a single item still needs one bit.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter.
//   req       : request vector
//   ptr       : highest-priority index for this cycle (kept by the parent)
//   enable    : when low no grant is produced
//   grant     : one-hot grant
//   grant_idx : index of the granted request
//   any_grant : a grant was produced
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IW      = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      grant_idx,
  output logic               any_grant
);

  always_comb begin
    int idx;
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    idx       = 0;
    if (enable) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        // Explicit wrap so non-power-of-two NUM_REQ works.
        idx = int'(ptr) + k;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        if (!any_grant && req[idx]) begin
          any_grant  = 1'b1;
          grant[idx] = 1'b1;
          grant_idx  = IW'(idx);
        end
      end
    end
  end

endmodule

// File: rtl/regfile_gpu_arbiter.sv
// regfile_gpu_arbiter: shares the GPU port of the integer register file among
// NUM_REQ requesters through a one-entry issue slot.
//   clk, reset            : clock, synchronous active-high reset
//   interrupt             : blocks new acceptances while high
//   req_valid/we/addr/wdata : per-requester requests (packed, requester i at [i*W +: W])
//   req_ready             : one-hot acceptance pulse
//   rsp_valid, rsp_data   : one-hot read response, one cycle after the access
//   cpu_w_en, cpu_w_rd    : CPU writeback port (for collision detection)
//   rf_*                  : register-file GPU port
//   busy                  : issue slot occupied
//   dbg_state, dbg_rr_ptr : FSM state and round-robin pointer
//   stat_grants, stat_holds : saturating counters, only with REGARB_STATS_EN
//
// Handshake: a request is held with stable payload while req_valid is high;
// it is transferred in the cycle req_ready[i] is high (valid & ready).
module regfile_gpu_arbiter
  import regarb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 64,
  parameter int REG_NUM    = 32,
  parameter int AW         = clog2_min1(REG_NUM),
  parameter int IW         = clog2_min1(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          interrupt,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*AW-1:0]         req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  input  logic                          cpu_w_en,
  input  logic [AW-1:0]                 cpu_w_rd,
  output logic [AW-1:0]                 rf_rs_gpu,
  input  logic [DATA_WIDTH-1:0]         rf_read_gpu,
  output logic                          rf_w_en_gpu,
  output logic [AW-1:0]                 rf_w_rd_gpu,
  output logic [DATA_WIDTH-1:0]         rf_w_result_gpu,
  output logic                          busy,
  output arb_state_e                    dbg_state,
  output logic [IW-1:0]                 dbg_rr_ptr
`ifdef REGARB_STATS_EN
  ,
  output logic [31:0]                   stat_grants,
  output logic [31:0]                   stat_holds
`endif
);

  typedef struct packed {
    logic [IW-1:0]         id;
    logic                  we;
    logic [AW-1:0]         addr;
    logic [DATA_WIDTH-1:0] wdata;
  } slot_t;

  arb_state_e            state_q;
  slot_t                 slot_q, next_slot;
  logic [IW-1:0]         rr_ptr;
  logic [AW-1:0]         rs_hold, wrd_hold;
  logic [DATA_WIDTH-1:0] wres_hold;
  logic                  conflict, complete, accept_en;
  logic [NUM_REQ-1:0]    grant;
  logic [IW-1:0]         grant_idx;
  logic                  any_grant;

  // x0 is never written by either port, so it cannot collide.
  assign conflict  = cpu_w_en && (cpu_w_rd == slot_q.addr) && (slot_q.addr != '0);
  assign complete  = !reset && (state_q == ISSUE) && !conflict;
  assign accept_en = !reset && !interrupt &&
                     ((state_q == IDLE) || ((state_q == ISSUE) && !conflict));

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .enable    (accept_en),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  always_comb begin
    next_slot    = slot_q;
    next_slot.id = grant_idx;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        next_slot.we    = req_we[i];
        next_slot.addr  = req_addr[i*AW +: AW];
        next_slot.wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign req_ready  = grant;
  assign busy       = (state_q != IDLE);
  assign dbg_state  = state_q;
  assign dbg_rr_ptr = rr_ptr;

  // Port drive is live only in a completing cycle; otherwise the address and
  // data lines keep their last driven values.
  assign rf_rs_gpu       = (complete && !slot_q.we) ? slot_q.addr  : rs_hold;
  assign rf_w_en_gpu     = complete && slot_q.we && (slot_q.addr != '0);
  assign rf_w_rd_gpu     = (complete && slot_q.we) ? slot_q.addr  : wrd_hold;
  assign rf_w_result_gpu = (complete && slot_q.we) ? slot_q.wdata : wres_hold;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      slot_q    <= '0;
      rr_ptr    <= '0;
      rs_hold   <= '0;
      wrd_hold  <= '0;
      wres_hold <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= '0;
      if (complete) begin
        if (slot_q.we) begin
          wrd_hold  <= slot_q.addr;
          wres_hold <= slot_q.wdata;
        end else begin
          rs_hold               <= slot_q.addr;
          rsp_valid[slot_q.id]  <= 1'b1;
          rsp_data              <= rf_read_gpu;
        end
      end
      if (any_grant) begin
        slot_q <= next_slot;
        rr_ptr <= (grant_idx == IW'(NUM_REQ - 1)) ? '0 : grant_idx + IW'(1);
      end
      case (state_q)
        IDLE:    if (any_grant) state_q <= ISSUE;
        ISSUE: begin
          if (conflict)       state_q <= HOLD;
          else if (any_grant) state_q <= ISSUE;
          else                state_q <= IDLE;
        end
        // A cleared conflict retries through ISSUE on the following cycle.
        HOLD:    if (!conflict) state_q <= ISSUE;
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef REGARB_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_grants <= '0;
      stat_holds  <= '0;
    end else begin
      if (any_grant && (stat_grants != '1))         stat_grants <= stat_grants + 32'd1;
      if ((state_q == HOLD) && (stat_holds != '1))  stat_holds  <= stat_holds + 32'd1;
    end
  end
`endif

endmodule
